// File: rtl/riscv_pkg.sv
// Shared RV32 encodings used by the next-PC logic: branch funct3 values,
// the JALR alignment mask and the sequential fetch step.
package riscv_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
    localparam logic [63:0] INSN_ALIGN = ~64'd1;

    localparam int PC_STEP = 4;

    function automatic logic is_reserved_br(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Pure combinational RV32 branch condition evaluator. Reserved funct3 codes
// never take the branch and are flagged as illegal.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            illegal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (rs1 == rs2);
    assign w_lt  = ($signed(rs1) < $signed(rs2));
    assign w_ltu = (rs1 < rs2);

    always_comb begin
        cond    = 1'b0;
        illegal = is_reserved_br(funct3);
        case (funct3)
            BR_EQ:   cond = w_eq;
            BR_NE:   cond = ~w_eq;
            BR_LT:   cond = w_lt;
            BR_GE:   cond = ~w_lt;
            BR_LTU:  cond = w_ltu;
            BR_GEU:  cond = ~w_ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Next-PC controller between EX and IF: resolves branches/jumps, owns the fetch
// PC, drives the multi-cycle IF/ID flush and keeps saturating branch statistics.
module pc_redirect_unit
    import riscv_pkg::*;
#(
    parameter int                   XLEN        = 32,
    parameter logic [XLEN-1:0]      RESET_PC    = '0,
    parameter int                   FLUSH_DEPTH = 2,
    parameter int                   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic             jump_i,
    input  logic             jalr_i,
    input  logic             branch_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_ex_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_src_o,
    output logic [XLEN-1:0]  target_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic             illegal_br_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [XLEN-1:0]  STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0]  ALIGN_MASK = INSN_ALIGN[XLEN-1:0];

    logic [XLEN-1:0]  r_pc;
    logic [2:0]       r_flush_cnt;
    logic             r_misalign;
    logic             r_illegal;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_cond;
    logic             w_illegal;
    logic             w_active;
    logic             w_taken;
    logic             w_misalign;
    logic             w_br_inc;
    logic             w_taken_inc;
    logic [XLEN-1:0]  w_branch_tgt;
    logic [XLEN-1:0]  w_jalr_tgt;

    branch_cmp #(
        .XLEN(XLEN)
    ) u_branch_cmp (
        .funct3  (funct3_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .cond    (w_cond),
        .illegal (w_illegal)
    );

    // Anything in EX while the flush is active is a wrong-path instruction.
    assign w_active     = ex_valid_i & ~stall_i & ~flush_o;
    assign w_branch_tgt = pc_ex_i + imm_i;
    assign w_jalr_tgt   = (rs1_i + imm_i) & ALIGN_MASK;

    assign target_o   = jalr_i ? w_jalr_tgt : w_branch_tgt;
    assign w_taken    = w_active & (jump_i | jalr_i | (branch_i & w_cond));
    assign w_misalign = w_taken & target_o[1];
    assign pc_src_o   = w_taken & ~target_o[1];

    // A jump sharing the slot with branch_i only bumps the resolved-branch count.
    assign w_br_inc    = branch_i & w_active;
    assign w_taken_inc = w_br_inc & w_cond & ~target_o[1] & ~jump_i & ~jalr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (pc_src_o) begin
            r_pc <= target_o;
        end else if (!stall_i) begin
            r_pc <= r_pc + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_cnt <= 3'd0;
        end else if (pc_src_o) begin
            r_flush_cnt <= FLUSH_INIT;
        end else if (!stall_i && (r_flush_cnt != 3'd0)) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            r_illegal  <= w_br_inc & w_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else begin
            if (w_br_inc && (r_br_cnt != CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_taken_inc && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign pc_o         = r_pc;
    assign flush_o      = (r_flush_cnt != 3'd0);
    assign misalign_o   = r_misalign;
    assign illegal_br_o = r_illegal;
    assign br_cnt_o     = r_br_cnt;
    assign taken_cnt_o  = r_taken_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; counters use a narrow width so that
// saturation is reachable with a short run of branches.
module tb_pc_redirect_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stall_i;
    logic             ex_valid_i;
    logic             jump_i;
    logic             jalr_i;
    logic             branch_i;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [XLEN-1:0]  pc_ex_i;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  pc_o;
    logic             pc_src_o;
    logic [XLEN-1:0]  target_o;
    logic             flush_o;
    logic             misalign_o;
    logic             illegal_br_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] taken_cnt_o;

    int compared;
    int mismatched;

    pc_redirect_unit #(
        .XLEN        (XLEN),
        .RESET_PC    (32'h0),
        .FLUSH_DEPTH (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .ex_valid_i   (ex_valid_i),
        .jump_i       (jump_i),
        .jalr_i       (jalr_i),
        .branch_i     (branch_i),
        .funct3_i     (funct3_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .pc_ex_i      (pc_ex_i),
        .imm_i        (imm_i),
        .pc_o         (pc_o),
        .pc_src_o     (pc_src_o),
        .target_o     (target_o),
        .flush_o      (flush_o),
        .misalign_o   (misalign_o),
        .illegal_br_o (illegal_br_o),
        .br_cnt_o     (br_cnt_o),
        .taken_cnt_o  (taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 1'b0;
        jump_i     = 1'b0;
        jalr_i     = 1'b0;
        branch_i   = 1'b0;
        funct3_i   = 3'b000;
        rs1_i      = '0;
        rs2_i      = '0;
        pc_ex_i    = '0;
        imm_i      = '0;
    endtask

    task automatic applyStimulus(input logic j, input logic jr, input logic br, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm);
        ex_valid_i = 1'b1;
        jump_i     = j;
        jalr_i     = jr;
        branch_i   = br;
        funct3_i   = f3;
        rs1_i      = a;
        rs2_i      = b;
        pc_ex_i    = pc;
        imm_i      = imm;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        stall_i    = 1'b0;
        idle();

        // Reset held for two edges
        step();
        step();
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_flush", {31'd0, flush_o}, 32'd0);
        checkOutput("rst_br_cnt", {28'd0, br_cnt_o}, 32'd0);
        checkOutput("rst_taken_cnt", {28'd0, taken_cnt_o}, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign_o}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal_br_o}, 32'd0);

        rst_n = 1'b1;
        step();
        checkOutput("run_pc4", pc_o, 32'h4);
        step();
        checkOutput("run_pc8", pc_o, 32'h8);

        // BEQ 5==5 at 0x100 + 0x20
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        checkOutput("beq_src", {31'd0, pc_src_o}, 32'd1);
        checkOutput("beq_tgt", target_o, 32'h120);
        step();
        checkOutput("beq_pc", pc_o, 32'h120);
        checkOutput("beq_flush1", {31'd0, flush_o}, 32'd1);
        checkOutput("beq_taken_cnt", {28'd0, taken_cnt_o}, 32'd1);
        checkOutput("beq_br_cnt", {28'd0, br_cnt_o}, 32'd1);
        // Same branch still in EX during the flush is squashed
        #1;
        checkOutput("squash_src", {31'd0, pc_src_o}, 32'd0);
        step();
        checkOutput("beq_flush2", {31'd0, flush_o}, 32'd1);
        checkOutput("beq_pc_after", pc_o, 32'h124);
        checkOutput("squash_br_cnt", {28'd0, br_cnt_o}, 32'd1);
        idle();
        step();
        checkOutput("beq_flush_end", {31'd0, flush_o}, 32'd0);
        checkOutput("beq_pc_end", pc_o, 32'h128);

        // BLT -1 < 1 signed
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        checkOutput("blt_src", {31'd0, pc_src_o}, 32'd1);
        step();
        checkOutput("blt_pc", pc_o, 32'h240);
        checkOutput("blt_taken_cnt", {28'd0, taken_cnt_o}, 32'd2);
        idle();
        step();
        step();
        checkOutput("blt_pc_end", pc_o, 32'h248);

        // BLTU 0xFFFFFFFF < 1 unsigned is false
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        checkOutput("bltu_src", {31'd0, pc_src_o}, 32'd0);
        step();
        checkOutput("bltu_pc", pc_o, 32'h24C);
        checkOutput("bltu_br_cnt", {28'd0, br_cnt_o}, 32'd3);
        checkOutput("bltu_taken_cnt", {28'd0, taken_cnt_o}, 32'd2);
        checkOutput("bltu_flush", {31'd0, flush_o}, 32'd0);

        // JALR to 0x202 is misaligned, 0x204 redirects
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'h0, 32'h0);
        checkOutput("jalr_mis_tgt", target_o, 32'h202);
        checkOutput("jalr_mis_src", {31'd0, pc_src_o}, 32'd0);
        step();
        checkOutput("jalr_mis_pulse", {31'd0, misalign_o}, 32'd1);
        checkOutput("jalr_mis_pc", pc_o, 32'h250);
        checkOutput("jalr_mis_flush", {31'd0, flush_o}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'h0, 32'h1);
        checkOutput("jalr_tgt", target_o, 32'h204);
        checkOutput("jalr_src", {31'd0, pc_src_o}, 32'd1);
        step();
        checkOutput("jalr_mis_clear", {31'd0, misalign_o}, 32'd0);
        checkOutput("jalr_pc", pc_o, 32'h204);
        checkOutput("jalr_flush", {31'd0, flush_o}, 32'd1);
        idle();
        step();
        step();
        checkOutput("jalr_pc_end", pc_o, 32'h20C);

        // JAL held off by stall, then flush stretched by a stall
        stall_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h300, 32'h10);
        checkOutput("stall_src", {31'd0, pc_src_o}, 32'd0);
        step();
        checkOutput("stall_pc_hold", pc_o, 32'h20C);
        stall_i = 1'b0;
        #1;
        checkOutput("unstall_src", {31'd0, pc_src_o}, 32'd1);
        step();
        checkOutput("jal_pc", pc_o, 32'h310);
        idle();
        stall_i = 1'b1;
        step();
        checkOutput("flush_stall_pc", pc_o, 32'h310);
        checkOutput("flush_stall_f", {31'd0, flush_o}, 32'd1);
        stall_i = 1'b0;
        step();
        checkOutput("flush_ext_f", {31'd0, flush_o}, 32'd1);
        checkOutput("flush_ext_pc", pc_o, 32'h314);
        step();
        checkOutput("flush_ext_end", {31'd0, flush_o}, 32'd0);
        checkOutput("flush_ext_pc2", pc_o, 32'h318);

        // Reserved funct3 010
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'd0, 32'd0, 32'h400, 32'h8);
        checkOutput("ill_src", {31'd0, pc_src_o}, 32'd0);
        step();
        checkOutput("ill_pulse", {31'd0, illegal_br_o}, 32'd1);
        checkOutput("ill_br_cnt", {28'd0, br_cnt_o}, 32'd4);
        idle();
        step();
        checkOutput("ill_clear", {31'd0, illegal_br_o}, 32'd0);
        checkOutput("ill_pc", pc_o, 32'h320);

        // JAL with branch_i also set: br_cnt only
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 32'h500, 32'h20);
        checkOutput("jbr_src", {31'd0, pc_src_o}, 32'd1);
        step();
        checkOutput("jbr_pc", pc_o, 32'h520);
        checkOutput("jbr_br_cnt", {28'd0, br_cnt_o}, 32'd5);
        checkOutput("jbr_taken_cnt", {28'd0, taken_cnt_o}, 32'd2);
        idle();
        step();
        step();

        // Drive taken BNEs until both counters pin at 15
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 32'h600, 32'h10);
            step();
            idle();
            step();
            step();
        end
        checkOutput("sat_br_cnt", {28'd0, br_cnt_o}, 32'd15);
        checkOutput("sat_taken_cnt", {28'd0, taken_cnt_o}, 32'd15);
        checkOutput("sat_pc", pc_o, 32'h618);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 32'd1, 32'd2, 32'h600, 32'h10);
        step();
        checkOutput("sat_br_hold", {28'd0, br_cnt_o}, 32'd15);
        checkOutput("sat_taken_hold", {28'd0, taken_cnt_o}, 32'd15);
        checkOutput("sat_flush", {31'd0, flush_o}, 32'd1);

        // Reset during flush and stall
        idle();
        rst_n   = 1'b0;
        stall_i = 1'b1;
        step();
        checkOutput("mrst_pc", pc_o, 32'h0);
        checkOutput("mrst_flush", {31'd0, flush_o}, 32'd0);
        checkOutput("mrst_br_cnt", {28'd0, br_cnt_o}, 32'd0);
        checkOutput("mrst_taken_cnt", {28'd0, taken_cnt_o}, 32'd0);
        rst_n   = 1'b1;
        stall_i = 1'b0;
        step();
        checkOutput("mrst_run", pc_o, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
